alu_cmd_ctrl: RTL

- Front-end sequencer for the shared 8-bit ALU in the final system.
- Receives 3-word command frames (header, operand A, operand B) from the serial RX path.
- Drives the ALU's A/B/EN/ALU_FUN, captures the 2*DATA_WIDTH result, and returns it low word first over a valid/ready TX interface.
- Owns the ALU exclusively: one command in flight; words arriving while busy are dropped.

---
 rtl/alu_cmd_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: 3-word command sequencer for the shared ALU; `define ALU_CTRL_DIV0_CHECK_EN to short-circuit divide-by-zero
module alu_cmd_ctrl #(
    parameter int         DATA_WIDTH = 8,
    parameter logic [3:0] HDR_TAG    = 4'hA
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_DATA,
    input  logic                      RX_VALID,
    output logic [DATA_WIDTH-1:0]     ALU_A,
    output logic [DATA_WIDTH-1:0]     ALU_B,
    output logic [3:0]                ALU_FUN,
    output logic                      ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0]     TX_DATA,
    output logic                      TX_VALID,
    input  logic                      TX_READY,
    output logic                      BUSY,
    output logic                      FRAME_ERR
);
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, WAIT_ALU, SEND_LO, SEND_HI} state_t;
    state_t                  state, state_d;
    logic [2*DATA_WIDTH-1:0] res, res_d;
    logic [DATA_WIDTH-1:0]   a_d, b_d;
    logic [3:0]              fun_d;
    logic                    fe_d, div0, txv_d;
`ifdef ALU_CTRL_DIV0_CHECK_EN
    assign div0 = ALU_FUN == 4'b0011 && RX_DATA == '0;
`else
    assign div0 = 1'b0;
`endif
    assign txv_d = state_d == SEND_LO || state_d == SEND_HI;
    always_comb begin
        state_d = state;
        a_d     = ALU_A;
        b_d     = ALU_B;
        fun_d   = ALU_FUN;
        res_d   = res;
        fe_d    = 1'b0;
        case (state)
            IDLE: if (RX_VALID) begin
                if (RX_DATA[7:4] == HDR_TAG) begin
                    fun_d   = RX_DATA[3:0];
                    state_d = GET_A;
                end else fe_d = 1'b1;
            end
            GET_A: if (RX_VALID) begin
                a_d     = RX_DATA;
                state_d = GET_B;
            end
            GET_B: if (RX_VALID) begin
                b_d     = RX_DATA;
                fe_d    = div0;
                res_d   = div0 ? '1 : res;
                state_d = div0 ? SEND_LO : EXEC;
            end
            EXEC: state_d = WAIT_ALU;
            WAIT_ALU: if (ALU_OUT_VALID) begin
                res_d   = ALU_OUT;
                state_d = SEND_LO;
            end
            SEND_LO: state_d = TX_READY ? SEND_HI : SEND_LO;
            SEND_HI: state_d = TX_READY ? IDLE : SEND_HI;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            res       <= '0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_FUN   <= '0;
            ALU_EN    <= 1'b0;
            TX_DATA   <= '0;
            TX_VALID  <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state     <= state_d;
            res       <= res_d;
            ALU_A     <= a_d;
            ALU_B     <= b_d;
            ALU_FUN   <= fun_d;
            ALU_EN    <= state_d == EXEC;
            TX_DATA   <= !txv_d ? '0 : state_d == SEND_HI ? res_d[2*DATA_WIDTH-1:DATA_WIDTH] : res_d[DATA_WIDTH-1:0];
            TX_VALID  <= txv_d;
            BUSY      <= state_d != IDLE;
            FRAME_ERR <= fe_d;
        end
    end
endmodule
